// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared types and helpers for the hanoi_pegs move engine.
//   err_e   - response status codes (OK, SAME_PEG, BAD_PEG, EMPTY_SRC, BIGGER)
//   state_e - engine FSM encoding
//   spw_f / pw_f - stack-pointer / peg-index width helpers
//   peg_field    - extract field idx (width spw) from a peg entry
package hanoi_pkg;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_SAME_PEG  = 3'd1,
    ERR_BAD_PEG   = 3'd2,
    ERR_EMPTY_SRC = 3'd3,
    ERR_BIGGER    = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Upper bounds for the generic field extractor; entries are zero-extended.
  localparam int PEG_MAXW = 512;
  localparam int FLD_MAXW = 16;

  function automatic int spw_f(input int s);
    return (s < 1) ? 1 : $clog2(s + 1);
  endfunction

  function automatic int pw_f(input int p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

  // Field idx of a peg entry; caller guarantees idx >= 0.
  function automatic logic [FLD_MAXW-1:0] peg_field(input logic [PEG_MAXW-1:0] ent,
                                                    input int idx, input int spw);
    logic [PEG_MAXW-1:0] sh;
    sh = ent >> (idx * spw);
    return FLD_MAXW'(sh) & FLD_MAXW'((1 << spw) - 1);
  endfunction

endpackage

// File: rtl/hanoi_peg_rf.sv
// hanoi_peg_rf: P-entry peg register file.
//   clk, rst            - clock, synchronous active-high reset (preloads peg 0)
//   ra_a/rd_a, ra_b/rd_b - two asynchronous read ports (out-of-range reads 0)
//   we                  - shared write enable for both write ports
//   wa_a/wd_a, wa_b/wd_b - two write ports, written on the same edge
//   ent_o               - all entries, for status/solved decoding
module hanoi_peg_rf
  import hanoi_pkg::*;
#(
  parameter int S   = 3,
  parameter int P   = 3,
  parameter int SPW = 2,
  parameter int PW  = 2,
  localparam int EW = (S + 1) * SPW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PW-1:0]         ra_a,
  output logic [EW-1:0]         rd_a,
  input  logic [PW-1:0]         ra_b,
  output logic [EW-1:0]         rd_b,
  input  logic                  we,
  input  logic [PW-1:0]         wa_a,
  input  logic [EW-1:0]         wd_a,
  input  logic [PW-1:0]         wa_b,
  input  logic [EW-1:0]         wd_b,
  output logic [P-1:0][EW-1:0]  ent_o
);

  logic [P-1:0][EW-1:0] mem_q, mem_d;

  // Peg 0 holds S..1 from the bottom with sp=S; all other pegs empty.
  function automatic logic [P-1:0][EW-1:0] reset_image();
    logic [P-1:0][EW-1:0] img;
    img = '0;
    for (int i = 0; i < S; i++) img[0][i*SPW +: SPW] = SPW'(S - i);
    img[0][EW-1 -: SPW] = SPW'(S);
    return img;
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      if (int'(wa_a) < P) mem_d[wa_a] = wd_a;
      if (int'(wa_b) < P) mem_d[wa_b] = wd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= reset_image();
    else     mem_q <= mem_d;
  end

  assign rd_a  = (int'(ra_a) < P) ? mem_q[ra_a] : '0;
  assign rd_b  = (int'(ra_b) < P) ? mem_q[ra_b] : '0;
  assign ent_o = mem_q;

endmodule

// File: rtl/hanoi_pegs.sv
// hanoi_pegs: Tower-of-Hanoi move engine, one legality-checked move per request.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_fr/req_to are peg indices
//   rsp_valid             - one-cycle response strobe with rsp_ok / rsp_err
//   move_cnt              - saturating count of committed moves
//   solved                - registered: all disks ordered on peg P-1
//   peg_sp_o / top_o      - per-peg disk count / top disk size (0 = empty)
// Build option: HANOI_LEGAL_CHECK_EN enables the BIGGER (large-on-small) check.
module hanoi_pegs
  import hanoi_pkg::*;
#(
  parameter int S     = 3,
  parameter int P     = 3,
  parameter int CNT_W = 16,
  localparam int SPW  = spw_f(S),
  localparam int PW   = pw_f(P)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PW-1:0]      req_fr,
  input  logic [PW-1:0]      req_to,
  output logic               rsp_valid,
  output logic               rsp_ok,
  output logic [2:0]         rsp_err,
  output logic [CNT_W-1:0]   move_cnt,
  output logic               solved,
  output logic [P*SPW-1:0]   peg_sp_o,
  output logic [P*SPW-1:0]   top_o
);

  localparam int EW = (S + 1) * SPW;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] CHECK  = ST_CHECK;
  localparam logic [1:0] COMMIT = ST_COMMIT;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        fr_q, fr_d, to_q, to_d;
  logic [2:0]           err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 solved_q, solved_d;

  logic                 we;
  logic [EW-1:0]        rd_fr, rd_to, wd_fr, wd_to;
  logic [P-1:0][EW-1:0] ent;
  logic [SPW-1:0]       sp_fr, sp_to, top_fr;
  err_e                 chk_err;

  function automatic logic [SPW-1:0] top_of(input logic [EW-1:0] e);
    logic [SPW-1:0] sp;
    sp = e[EW-1 -: SPW];
    if (sp == '0) return '0;
    return SPW'(peg_field(PEG_MAXW'(e), int'(sp) - 1, SPW));
  endfunction

  hanoi_peg_rf #(.S(S), .P(P), .SPW(SPW), .PW(PW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra_a  (fr_q),
    .rd_a  (rd_fr),
    .ra_b  (to_q),
    .rd_b  (rd_to),
    .we    (we),
    .wa_a  (fr_q),
    .wd_a  (wd_fr),
    .wa_b  (to_q),
    .wd_b  (wd_to),
    .ent_o (ent)
  );

  assign sp_fr  = rd_fr[EW-1 -: SPW];
  assign sp_to  = rd_to[EW-1 -: SPW];
  assign top_fr = top_of(rd_fr);

  // Legality check on the latched request; priority is the if-chain order.
  always_comb begin
`ifdef HANOI_LEGAL_CHECK_EN
    logic [SPW-1:0] top_to;
    top_to = top_of(rd_to);
`endif
    chk_err = ERR_OK;
    if (int'(fr_q) >= P || int'(to_q) >= P) chk_err = ERR_BAD_PEG;
    else if (fr_q == to_q)                  chk_err = ERR_SAME_PEG;
    else if (sp_fr == '0)                   chk_err = ERR_EMPTY_SRC;
`ifdef HANOI_LEGAL_CHECK_EN
    else if (sp_to != '0 && top_fr > top_to) chk_err = ERR_BIGGER;
`endif
  end

  // Pop/push images. Indices are clamped so the part-selects stay in range
  // in states where the write is not enabled.
  always_comb begin
    int fi, ti;
    fi = (sp_fr == '0) ? 0 : int'(sp_fr) - 1;
    ti = (int'(sp_to) < S) ? int'(sp_to) : S - 1;
    wd_fr = rd_fr;
    wd_fr[fi*SPW +: SPW] = '0;
    wd_fr[EW-1 -: SPW]   = sp_fr - SPW'(1);
    wd_to = rd_to;
    wd_to[ti*SPW +: SPW] = top_fr;
    wd_to[EW-1 -: SPW]   = sp_to + SPW'(1);
  end

  always_comb begin
    state_d = state_q;
    fr_d    = fr_q;
    to_d    = to_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        fr_d    = req_fr;
        to_d    = req_to;
        state_d = CHECK;
      end
      CHECK: begin
        err_d   = chk_err;
        state_d = (chk_err == ERR_OK) ? COMMIT : RESP;
      end
      COMMIT: begin
        we = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Without the ordering rule, sp==S alone does not imply a solved stack,
  // so every slot is compared against its expected size.
  always_comb begin
    solved_d = (int'(ent[P-1][EW-1 -: SPW]) == S);
`ifndef HANOI_LEGAL_CHECK_EN
    for (int i = 0; i < S; i++)
      if (int'(ent[P-1][i*SPW +: SPW]) != S - i) solved_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fr_q     <= '0;
      to_q     <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
      solved_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fr_q     <= fr_d;
      to_q     <= to_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      solved_q <= solved_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid ? err_q : 3'd0;
  assign rsp_ok    = rsp_valid && (err_q == 3'd0);
  assign move_cnt  = cnt_q;
  assign solved    = solved_q;

  for (genvar k = 0; k < P; k++) begin : g_peg
    assign peg_sp_o[k*SPW +: SPW] = ent[k][EW-1 -: SPW];
    assign top_o[k*SPW +: SPW]    = top_of(ent[k]);
  end

endmodule

// File: tb/tb_hanoi_pegs.sv
// Directed bench for hanoi_pegs with S=3, P=3 and a 3-bit move counter so
// that saturation is reachable right after the optimal 7-move solution.
// Packed per-peg views: {peg2, peg1, peg0}, 2 bits each.
module tb_hanoi_pegs;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_fr, req_to;
  logic       rsp_valid, rsp_ok;
  logic [2:0] rsp_err;
  logic [2:0] move_cnt;
  logic       solved;
  logic [5:0] peg_sp_o, top_o;

  int   vectors = 0;
  int   miscompares = 0;
  logic sol_rsp;

  always #5 clk = ~clk;

  hanoi_pegs #(.S(3), .P(3), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fr    (req_fr),
    .req_to    (req_to),
    .rsp_valid (rsp_valid),
    .rsp_ok    (rsp_ok),
    .rsp_err   (rsp_err),
    .move_cnt  (move_cnt),
    .solved    (solved),
    .peg_sp_o  (peg_sp_o),
    .top_o     (top_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pegs(input string tag, input logic [5:0] sp, input logic [5:0] tp,
                      input int cnt);
    chk({tag, ".sp"},  peg_sp_o, sp);
    chk({tag, ".top"}, top_o, tp);
    chk({tag, ".cnt"}, move_cnt, cnt);
  endtask

  // Issues one request and holds req_valid until the response so that a
  // second acceptance would show up in move_cnt. Latency is counted in edges
  // after the accepting edge: legal 2 (CHECK, COMMIT), illegal 1 (CHECK).
  task automatic do_move(input string tag, input int fr, input int to, input int exp_err);
    int n;
    bit seen;
    chk({tag, ".ready_in"}, req_ready, 1);
    req_valid = 1'b1;
    req_fr    = 2'(fr);
    req_to    = 2'(to);
    step();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      step();
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    chk({tag, ".lat"}, seen ? n : 99, (exp_err == 0) ? 2 : 1);
    chk({tag, ".err"}, rsp_err, exp_err);
    chk({tag, ".ok"},  rsp_ok, (exp_err == 0) ? 1 : 0);
    chk({tag, ".busy"}, req_ready, 0);
    sol_rsp   = solved;
    req_valid = 1'b0;
    step();
    chk({tag, ".strobe"}, rsp_valid, 0);
    chk({tag, ".ready_out"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_fr = '0;
    req_to = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_ok", rsp_ok, 0);
    chk("rst.rsp_err", rsp_err, 0);
    chk("rst.solved", solved, 0);
    pegs("rst", 6'h03, 6'h01, 0);

    // First legal move: disk 1 to peg 2
    do_move("m02", 0, 2, 0);
    pegs("m02", 6'h12, 6'h12, 1);

    // Disk 2 onto disk 1
`ifdef HANOI_LEGAL_CHECK_EN
    do_move("bigger", 0, 2, 4);
    pegs("bigger", 6'h12, 6'h12, 1);
`else
    do_move("bigger", 0, 2, 0);
    pegs("bigger", 6'h21, 6'h23, 2);
`endif

    // Rejections leave state alone
    do_move("empty", 1, 0, 3);
    do_move("badfr", 3, 0, 2);
    do_move("badboth", 3, 3, 2);
    do_move("same", 1, 1, 1);
`ifdef HANOI_LEGAL_CHECK_EN
    pegs("rejects", 6'h12, 6'h12, 1);
`else
    pegs("rejects", 6'h21, 6'h23, 2);
`endif

    rst = 1'b1;
    step();
    rst = 1'b0;
    pegs("rst2", 6'h03, 6'h01, 0);

    // Optimal solution
    do_move("o1", 0, 2, 0);
    do_move("o2", 0, 1, 0);
    pegs("o2", 6'h15, 6'h1B, 2);
    do_move("o3", 2, 1, 0);
    do_move("o4", 0, 2, 0);
    do_move("o5", 1, 0, 0);
    do_move("o6", 1, 2, 0);
    chk("o6.solved", solved, 0);
    do_move("o7", 0, 2, 0);
    chk("o7.solved_at_rsp", sol_rsp, 0);
    chk("o7.solved", solved, 1);
    pegs("o7", 6'h30, 6'h10, 7);

    // Move off the solved stack; counter is saturated at 7
    do_move("off", 2, 1, 0);
    chk("off.solved_at_rsp", sol_rsp, 1);
    chk("off.solved", solved, 0);
    pegs("off", 6'h24, 6'h24, 7);

    // Reset while in COMMIT: write must be dropped
    req_valid = 1'b1;
    req_fr = 2'd2;
    req_to = 2'd0;
    step();          // accepted, now CHECK
    step();          // now COMMIT
    chk("rc.busy", req_ready, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rc.rsp_valid", rsp_valid, 0);
    chk("rc.ready", req_ready, 1);
    pegs("rc", 6'h03, 6'h01, 0);
    step();
    chk("rc.rsp_valid2", rsp_valid, 0);
    pegs("rc2", 6'h03, 6'h01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hanoi_pegs.md
# hanoi_pegs

Parametrised Tower-of-Hanoi move engine: holds S disks across P pegs in a register file and executes one move per request through a valid/ready handshake. Every request is legality-checked and answered with a status code, and committed moves are counted. A solved flag reports when all disks sit in order on the last peg. It is the next-generation formal-verification target for puzzle properties such as reachability of the solved state and the minimum move count.

## Interface
Parameters:
- S, 3, number of disks (≥1)
- P, 3, number of pegs (≥3)
- CNT_W, 16, move-counter width

Derived widths: SPW = $clog2(S+1), PW = $clog2(P).

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  move request valid
- req_ready  out  1  engine can accept a request
- req_fr  in  PW  source peg index
- req_to  in  PW  destination peg index
- rsp_valid  out  1  one-cycle response strobe
- rsp_ok  out  1  move committed; valid with rsp_valid
- rsp_err  out  3  status code; valid with rsp_valid
- move_cnt  out  CNT_W  committed moves since reset
- solved  out  1  all S disks on peg P-1, ordered S..1 from bottom
- peg_sp_o  out  P*SPW  per-peg disk count; peg k at bits [k*SPW +: SPW]
- top_o  out  P*SPW  per-peg top disk size; 0 means empty

## Operation
- Peg entry layout: [(S+1)*SPW-1 -: SPW] holds the stack pointer. Slot i (0 = bottom) is at [i*SPW +: SPW]. Disk sizes run 1 (smallest) to S; 0 means no disk.
- Reset contents: peg 0 has sp=S and slots S, S-1, …, 1 from the bottom. All other pegs are zero.
- FSM states: IDLE, CHECK, COMMIT, RESP.
  - IDLE: req_ready=1. On req_valid, register req_fr and req_to and go to CHECK.
  - CHECK: read both pegs and evaluate the error code. Code 0 goes to COMMIT; any other code goes to RESP.
  - COMMIT: pop the source top (clear its slot, sp-1) and push onto the destination (slot sp_to, sp+1). Both pegs are written in the same edge. move_cnt is incremented here. Then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Error codes, priority highest first:
  - 2 BAD_PEG: req_fr≥P or req_to≥P
  - 1 SAME_PEG: req_fr==req_to
  - 3 EMPTY_SRC: sp_fr==0
  - 4 BIGGER: top_fr>top_to and sp_to≠0
  - 0 OK
- rsp_ok = (rsp_err==0). A rejected request leaves the pegs and move_cnt unchanged.
- move_cnt saturates at 2^CNT_W-1 and does not wrap.
- solved is registered and recomputed every cycle from the peg contents. It drops on the first committed move off the solved configuration.
- Reset mid-operation: the in-flight request is discarded, no write occurs, and the pegs return to their reset contents.
- No response backpressure: the requester must sample rsp_valid in that cycle.

## Timing
- Handshake: a request is accepted at edge t when req_valid && req_ready.
- Legal move: pegs are updated at edge t+2. rsp_valid is high in the cycle following edge t+2. req_ready is high again after edge t+3.
- Illegal move: rsp_valid is high in the cycle following edge t+1.
- req_ready=0 in CHECK, COMMIT and RESP. req_valid held during these states is ignored and not queued.
- peg_sp_o and top_o are combinational from the register file. solved lags a commit by one cycle.
- Reset values, in the cycle after rst deasserts:
  - req_ready=1, rsp_valid=0, rsp_ok=0, rsp_err=0
  - move_cnt=0, solved=0 (S≥1, P≥3)
  - peg_sp_o: peg0=S, others 0
  - top_o: peg0=1, others 0

## Configuration
- HANOI_LEGAL_CHECK_EN defined: full rule checking as above, including BIGGER.
- Not defined: the BIGGER check is removed, so a larger disk may land on a smaller one. BAD_PEG, SAME_PEG and EMPTY_SRC are still enforced because they protect storage integrity.
- In this mode solved additionally checks each slot i == S-i, since ordering is no longer guaranteed by the rules. With the macro this check is redundant but harmless.

## Structure
- Package hanoi_pkg holds:
  - err_e enum (OK, SAME_PEG, BAD_PEG, EMPTY_SRC, BIGGER)
  - state_e enum
  - SPW/PW width helper functions
  - peg-field slice function
- Sub-module hanoi_peg_rf: P entries, two async read ports, two write ports with a shared enable, reset preload of peg 0.
- Top level holds the FSM, checker, counter and solved logic.

## Test plan
All scenarios use S=3, P=3.
- Reset → peg_sp_o={0,0,3}, top_o peg0=1, move_cnt=0, solved=0, req_ready=1.
- Move 0→2 → rsp_valid 3 cycles after accept, rsp_err=0, peg_sp_o={1,0,2}, top_o peg2=1, move_cnt=1.
- Then 0→2 (disk 2 onto 1) → with macro: rsp_err=4, 2-cycle latency, state unchanged. Without macro: rsp_err=0 and peg2 sp=2.
- Move 1→0 from empty peg → rsp_err=3. Request fr=3 → rsp_err=2. Request fr=to=1 → rsp_err=1. move_cnt unchanged throughout.
- Optimal 7-move sequence (0→2, 0→1, 2→1, 0→2, 1→0, 1→2, 0→2) → move_cnt=7, solved=1 one cycle after the last commit. A following 2→1 clears solved.
- Assert rst during COMMIT → no write, pegs at reset contents, rsp_valid=0. A req_valid held while busy is not accepted twice.
